// File: rtl/mult_block_buffer.sv
// Multiply-and-buffer block: two-stage scaled/saturated multiplier feeding an
// external single-port memory as one block, then streaming that block back out.
module mult_block_buffer #(
    parameter int DATA_W    = 16,
    parameter int DEPTH     = 64,
    parameter int ADDR_W    = $clog2(DEPTH),
    parameter int SIGNED    = 1,
    parameter int FRAC_BITS = 0,
    parameter int SAT_EN    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              EN_mult,
    input  logic [DATA_W-1:0] mult_input0,
    input  logic [DATA_W-1:0] mult_input1,
    output logic              RDY_mult,
    input  logic              EN_flush,
    output logic              EN_writeMem,
    output logic [ADDR_W-1:0] writeMem_addr,
    output logic [DATA_W-1:0] writeMem_val,
    output logic              BLOCK_full,
    output logic [ADDR_W:0]   block_count,
    input  logic              EN_blockRead,
    output logic              EN_readMem,
    output logic [ADDR_W-1:0] readMem_addr,
    input  logic [DATA_W-1:0] readMem_val,
    output logic              VALID_memVal,
    output logic [DATA_W-1:0] memVal_data
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WRITE = 3'd1;
    localparam logic [2:0] S_DRAIN = 3'd2;
    localparam logic [2:0] S_FULL  = 3'd3;
    localparam logic [2:0] S_READ  = 3'd4;

    // Product is kept one bit wider than 2*DATA_W so the rounding add can never overflow.
    localparam int PW     = 2 * DATA_W + 1;
    localparam int RND_SH = (FRAC_BITS > 0) ? FRAC_BITS - 1 : 0;
    localparam logic signed [PW-1:0] RND  = (FRAC_BITS > 0) ? (PW'(1) << RND_SH) : '0;
    localparam logic signed [PW-1:0] SMAX = {{(DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [PW-1:0] SMIN = {{(DATA_W+2){1'b1}}, {(DATA_W-1){1'b0}}};
    localparam logic signed [PW-1:0] UMAX = {{(DATA_W+1){1'b0}}, {DATA_W{1'b1}}};
    localparam logic signed [PW-1:0] HI   = (SIGNED != 0) ? SMAX : UMAX;
    localparam logic signed [PW-1:0] LO   = (SIGNED != 0) ? SMIN : '0;
    localparam logic [ADDR_W:0] DEPTH_C   = (ADDR_W+1)'(DEPTH);

    logic [2:0]              state;
    logic                    started;
    logic [ADDR_W:0]         acc_cnt;
    logic                    drain_cnt;
    logic                    accept;
    logic                    p1_v;
    logic [ADDR_W-1:0]       p1_addr;
    logic signed [PW-1:0]    p1_prod;
    logic signed [PW-1:0]    a_x;
    logic signed [PW-1:0]    b_x;
    logic signed [PW-1:0]    rounded;
    logic signed [PW-1:0]    shifted;
    logic [DATA_W-1:0]       scaled;
    logic                    rd_en;
    logic                    rd_vld;
    logic [ADDR_W-1:0]       rd_addr;

    // started holds RDY_mult low until the first edge after reset release.
    assign RDY_mult     = started && ((state == S_IDLE) || ((state == S_WRITE) && (acc_cnt < DEPTH_C)));
    assign accept       = EN_mult && RDY_mult;
    assign BLOCK_full   = (state == S_FULL);
    assign block_count  = ((state == S_FULL) || (state == S_READ)) ? acc_cnt : '0;
    assign EN_readMem   = rd_en;
    assign readMem_addr = rd_addr;
    assign VALID_memVal = rd_vld;
    assign memVal_data  = rd_vld ? readMem_val : '0;

    // Sign- or zero-extend operands to the full product width.
    always_comb begin
        if (SIGNED != 0) begin
            a_x = {{(DATA_W+1){mult_input0[DATA_W-1]}}, mult_input0};
            b_x = {{(DATA_W+1){mult_input1[DATA_W-1]}}, mult_input1};
        end else begin
            a_x = {{(DATA_W+1){1'b0}}, mult_input0};
            b_x = {{(DATA_W+1){1'b0}}, mult_input1};
        end
    end

    // Round-half-up, fixed-point shift, then clamp or truncate to DATA_W.
    always_comb begin
        rounded = p1_prod + RND;
        shifted = rounded >>> FRAC_BITS;
        scaled  = shifted[DATA_W-1:0];
        if (SAT_EN != 0) begin
            if (shifted > HI) begin
                scaled = HI[DATA_W-1:0];
            end else if (shifted < LO) begin
                scaled = LO[DATA_W-1:0];
            end
        end
    end

    // Block control FSM: accept, drain, hold full, and sequence the readout.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            started   <= 1'b0;
            acc_cnt   <= '0;
            drain_cnt <= 1'b0;
            rd_en     <= 1'b0;
            rd_vld    <= 1'b0;
            rd_addr   <= '0;
        end else begin
            started <= 1'b1;
            rd_vld  <= rd_en;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        acc_cnt <= acc_cnt + 1'b1;
                        state   <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (accept) begin
                        acc_cnt <= acc_cnt + 1'b1;
                    end
                    if ((accept && (acc_cnt == DEPTH_C - 1'b1)) || EN_flush) begin
                        drain_cnt <= 1'b0;
                        state     <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    drain_cnt <= 1'b1;
                    if (drain_cnt) begin
                        state <= S_FULL;
                    end
                end
                S_FULL: begin
                    if (EN_blockRead) begin
                        rd_en   <= 1'b1;
                        rd_addr <= '0;
                        state   <= S_READ;
                    end
                end
                S_READ: begin
                    if (rd_en) begin
                        if ({1'b0, rd_addr} == acc_cnt - 1'b1) begin
                            rd_en <= 1'b0;
                        end else begin
                            rd_addr <= rd_addr + 1'b1;
                        end
                    end
                    // Last read data is on the bus this cycle; block is released at its end.
                    if (rd_vld && !rd_en) begin
                        acc_cnt <= '0;
                        state   <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Two-stage product pipeline ending in the memory write port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p1_v          <= 1'b0;
            p1_addr       <= '0;
            p1_prod       <= '0;
            EN_writeMem   <= 1'b0;
            writeMem_addr <= '0;
            writeMem_val  <= '0;
        end else begin
            p1_v        <= accept;
            EN_writeMem <= p1_v;
            if (accept) begin
                p1_addr <= acc_cnt[ADDR_W-1:0];
                p1_prod <= a_x * b_x;
            end
            if (p1_v) begin
                writeMem_addr <= p1_addr;
                writeMem_val  <= scaled;
            end
        end
    end

endmodule

// File: tb/tb_mult_block_buffer.sv
// Scoreboard bench for mult_block_buffer: three instances (saturating,
// wrapping, fixed-point) share one stimulus stream and one memory model each.
module tb_mult_block_buffer;

    localparam int W  = 16;
    localparam int D  = 64;
    localparam int AW = 6;

    typedef struct packed {
        logic [AW-1:0]       addr;
        logic [2:0][W-1:0]   d;
    } wexp_t;
    typedef logic [2:0][W-1:0] rexp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en_mult = 1'b0;
    logic en_flush = 1'b0;
    logic en_block_read = 1'b0;
    logic [W-1:0] in0 = '0;
    logic [W-1:0] in1 = '0;

    logic [2:0]           rdy, ewm, full, erm, vld;
    logic [2:0][AW-1:0]   waddr, raddr;
    logic [2:0][W-1:0]    wval, rmv, mvd;
    logic [2:0][AW:0]     bcnt;
    logic [W-1:0]         mem [3][D];

    wexp_t wq[$];
    rexp_t rq[$];
    int checks = 0;
    int errors = 0;
    int widx = 0;

    always #5 clk = ~clk;

    mult_block_buffer #(.DATA_W(W), .DEPTH(D), .SIGNED(1), .FRAC_BITS(0), .SAT_EN(1)) u_sat (
        .clk(clk), .rst(rst), .EN_mult(en_mult), .mult_input0(in0), .mult_input1(in1),
        .RDY_mult(rdy[0]), .EN_flush(en_flush), .EN_writeMem(ewm[0]), .writeMem_addr(waddr[0]),
        .writeMem_val(wval[0]), .BLOCK_full(full[0]), .block_count(bcnt[0]),
        .EN_blockRead(en_block_read), .EN_readMem(erm[0]), .readMem_addr(raddr[0]),
        .readMem_val(rmv[0]), .VALID_memVal(vld[0]), .memVal_data(mvd[0]));

    mult_block_buffer #(.DATA_W(W), .DEPTH(D), .SIGNED(1), .FRAC_BITS(0), .SAT_EN(0)) u_wrap (
        .clk(clk), .rst(rst), .EN_mult(en_mult), .mult_input0(in0), .mult_input1(in1),
        .RDY_mult(rdy[1]), .EN_flush(en_flush), .EN_writeMem(ewm[1]), .writeMem_addr(waddr[1]),
        .writeMem_val(wval[1]), .BLOCK_full(full[1]), .block_count(bcnt[1]),
        .EN_blockRead(en_block_read), .EN_readMem(erm[1]), .readMem_addr(raddr[1]),
        .readMem_val(rmv[1]), .VALID_memVal(vld[1]), .memVal_data(mvd[1]));

    mult_block_buffer #(.DATA_W(W), .DEPTH(D), .SIGNED(1), .FRAC_BITS(8), .SAT_EN(1)) u_frac (
        .clk(clk), .rst(rst), .EN_mult(en_mult), .mult_input0(in0), .mult_input1(in1),
        .RDY_mult(rdy[2]), .EN_flush(en_flush), .EN_writeMem(ewm[2]), .writeMem_addr(waddr[2]),
        .writeMem_val(wval[2]), .BLOCK_full(full[2]), .block_count(bcnt[2]),
        .EN_blockRead(en_block_read), .EN_readMem(erm[2]), .readMem_addr(raddr[2]),
        .readMem_val(rmv[2]), .VALID_memVal(vld[2]), .memVal_data(mvd[2]));

    // External memories: write on strobe, read data one cycle after strobe; junk otherwise.
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (ewm[k]) mem[k][waddr[k]] <= wval[k];
            rmv[k] <= erm[k] ? mem[k][raddr[k]] : 16'hA5A5;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pop and compare whenever any instance writes or presents read data.
    always @(negedge clk) begin
        wexp_t e;
        rexp_t r;
        if (ewm != 3'b000) begin
            if (wq.size() == 0) begin
                chk("unexpected_write", 64'(ewm), 64'h0);
            end else begin
                e = wq.pop_front();
                for (int k = 0; k < 3; k++) begin
                    chk("wr_strobe", 64'(ewm[k]), 64'h1);
                    chk("wr_addr", 64'(waddr[k]), 64'(e.addr));
                    chk("wr_data", 64'(wval[k]), 64'(e.d[k]));
                end
            end
        end
        if (vld != 3'b000) begin
            if (rq.size() == 0) begin
                chk("unexpected_valid", 64'(vld), 64'h0);
            end else begin
                r = rq.pop_front();
                for (int k = 0; k < 3; k++) begin
                    chk("rd_valid", 64'(vld[k]), 64'h1);
                    chk("rd_data", 64'(mvd[k]), 64'(r[k]));
                end
            end
        end else begin
            chk("memval_idle_zero", 64'(mvd[0]), 64'h0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] e0,
                        input logic [W-1:0] e1, input logic [W-1:0] e2, input logic fl);
        wexp_t e;
        rexp_t r;
        int n = 0;
        while (!rdy[0] && n < 200) begin
            tick();
            n++;
        end
        if (!rdy[0]) chk("send_rdy_timeout", 64'(rdy[0]), 64'h1);
        en_mult  = 1'b1;
        en_flush = fl;
        in0      = a;
        in1      = b;
        e.addr   = AW'(widx);
        e.d[0]   = e0;
        e.d[1]   = e1;
        e.d[2]   = e2;
        r        = e.d;
        wq.push_back(e);
        rq.push_back(r);
        widx++;
        tick();
        en_mult  = 1'b0;
        en_flush = 1'b0;
    endtask

    task automatic read_block(input int cnt);
        int n = 0;
        chk("block_full", 64'(full[0]), 64'h1);
        chk("block_count", 64'(bcnt[0]), 64'(cnt));
        en_block_read = 1'b1;
        tick();
        en_block_read = 1'b0;
        chk("read_start_strobe", 64'(erm[0]), 64'h1);
        chk("read_start_addr", 64'(raddr[0]), 64'h0);
        chk("full_drop_on_read", 64'(full[0]), 64'h0);
        while (rq.size() != 0 && n < 300) begin
            tick();
            n++;
        end
        chk("reads_outstanding", 64'(rq.size()), 64'h0);
        chk("rdy_after_read", 64'(rdy[0]), 64'h1);
        widx = 0;
    endtask

    task automatic check_reset(input string p);
        chk({p, "_rdy"}, 64'(rdy[0]), 64'h0);
        chk({p, "_wr_en"}, 64'(ewm[0]), 64'h0);
        chk({p, "_wr_addr"}, 64'(waddr[0]), 64'h0);
        chk({p, "_wr_val"}, 64'(wval[0]), 64'h0);
        chk({p, "_full"}, 64'(full[0]), 64'h0);
        chk({p, "_count"}, 64'(bcnt[0]), 64'h0);
        chk({p, "_rd_en"}, 64'(erm[0]), 64'h0);
        chk({p, "_rd_addr"}, 64'(raddr[0]), 64'h0);
        chk({p, "_valid"}, 64'(vld[0]), 64'h0);
    endtask

    task automatic release_reset();
        tick();
        tick();
        rst = 1'b1;
        chk("rdy_low_at_release", 64'(rdy[0]), 64'h0);
        tick();
        chk("rdy_after_release", 64'(rdy[0]), 64'h1);
    endtask

    initial begin
        #1;
        check_reset("por");
        release_reset();

        // Full block of (i, 3) back to back; EN_mult held high through DRAIN/FULL.
        for (int i = 0; i < D; i++) begin
            send(W'(i), 16'd3, W'(3 * i), W'(3 * i), W'((3 * i + 128) >> 8), 1'b0);
        end
        chk("rdy_low_after_depth", 64'(rdy[0]), 64'h0);
        en_mult = 1'b1;
        tick();
        chk("full_during_drain", 64'(full[0]), 64'h0);
        tick();
        chk("full_after_drain", 64'(full[0]), 64'h1);
        repeat (3) tick();
        chk("rdy_low_in_full", 64'(rdy[0]), 64'h0);
        en_mult = 1'b0;
        read_block(D);

        // Flushed 5-entry block with arithmetic corners, stalls and an ignored read request.
        send(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h0001, 16'h7FFF, 1'b0);
        send(16'h8000, 16'h7FFF, 16'h8000, 16'h8000, 16'h8000, 1'b0);
        tick();
        en_block_read = 1'b1;
        tick();
        en_block_read = 1'b0;
        chk("blockread_ignored_rd", 64'(erm[0]), 64'h0);
        chk("blockread_ignored_full", 64'(full[0]), 64'h0);
        send(16'h0180, 16'h0180, 16'h7FFF, 16'h4000, 16'h0240, 1'b0);
        tick();
        send(16'h0001, 16'h0080, 16'h0080, 16'h0080, 16'h0001, 1'b0);
        send(16'h0005, 16'hFFFD, 16'hFFF1, 16'hFFF1, 16'h0000, 1'b1);
        chk("rdy_low_after_flush", 64'(rdy[0]), 64'h0);
        tick();
        tick();
        read_block(5);

        // Reset during DRAIN: in-flight writes must be discarded.
        send(16'd1, 16'd1, 16'd1, 16'd1, 16'd0, 1'b0);
        send(16'd2, 16'd2, 16'd4, 16'd4, 16'd0, 1'b0);
        send(16'd3, 16'd3, 16'd9, 16'd9, 16'd0, 1'b1);
        rst = 1'b0;
        #1;
        check_reset("drain_rst");
        wq.delete();
        rq.delete();
        widx = 0;
        release_reset();

        // Reset during READ.
        send(16'd10, 16'd10, 16'h0064, 16'h0064, 16'h0000, 1'b0);
        send(16'h0100, 16'h0100, 16'h7FFF, 16'h0000, 16'h0100, 1'b0);
        send(16'hFFFF, 16'hFFFF, 16'h0001, 16'h0001, 16'h0000, 1'b0);
        send(16'hFF00, 16'h0100, 16'h8000, 16'h0000, 16'hFF00, 1'b1);
        tick();
        tick();
        chk("full_before_read_rst", 64'(full[0]), 64'h1);
        en_block_read = 1'b1;
        tick();
        en_block_read = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        check_reset("read_rst");
        wq.delete();
        rq.delete();
        widx = 0;
        release_reset();

        // Next block after reset starts at address 0.
        send(16'd2, 16'd3, 16'd6, 16'd6, 16'd0, 1'b0);
        send(16'hFFFF, 16'd2, 16'hFFFE, 16'hFFFE, 16'h0000, 1'b1);
        tick();
        tick();
        read_block(2);

        repeat (4) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
